univ_shift_reg: RTL

Parametrised universal shift register and the successor to the single-bit synchronous-reset D flip-flop. It keeps a WIDTH-bit register with a selectable active clock edge. It adds parallel load, logical/arithmetic shifts and rotates over a programmed number of positions, a synchronous clear and an enable. Multi-step operations run under a small busy/done command FSM, so a controller can issue one command and wait for completion.

---
 rtl/univ_shift_reg.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: parallel load, shifts and rotates over a
// programmed amount, synchronous clear, enable, and a busy/done command FSM.
module univ_shift_reg #(
  parameter int unsigned      WIDTH       = 8,
  parameter bit               NEG_EDGE    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned     CW          = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CW-1:0]    amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_LOAD = 3'd1,
    M_SHL  = 3'd2,
    M_SHR  = 3'd3,
    M_ROL  = 3'd4,
    M_ROR  = 3'd5,
    M_ASR  = 3'd6,
    M_ZERO = 3'd7
  } mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Inverting the clock for NEG_EDGE keeps a single register process for both edges.
  logic act_clk;
  assign act_clk = clock ^ NEG_EDGE;

  // NOTE: every state register, q included, takes its value from the async reset;
  // sequential state is assigned with <= only so all registers sample together.
  always_ff @(posedge act_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mode_q  <= M_HOLD;
      rem_q   <= '0;
      q_q     <= RESET_VALUE;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: each _d gets a hold default before any branch, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    q_d     = q_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
      rem_d   = '0;
      q_d     = RESET_VALUE;
      sout_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            unique case (mode_t'(mode))
              M_HOLD: done_d = 1'b1;
              M_LOAD: begin
                q_d    = d;
                done_d = 1'b1;
              end
              M_ZERO: begin
                q_d    = '0;
                done_d = 1'b1;
              end
              default: begin
                if (amount == '0) begin
                  done_d = 1'b1;
                end else begin
                  mode_d  = mode_t'(mode);
                  rem_d   = amount;
                  busy_d  = 1'b1;
                  state_d = S_RUN;
                end
              end
            endcase
          end
        end
        S_RUN: begin
          unique case (mode_q)
            M_SHL: begin
              q_d    = {q_q[WIDTH-2:0], sin};
              sout_d = q_q[WIDTH-1];
            end
            M_SHR: begin
              q_d    = {sin, q_q[WIDTH-1:1]};
              sout_d = q_q[0];
            end
            M_ROL: begin
              q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              sout_d = q_q[WIDTH-1];
            end
            M_ROR: begin
              q_d    = {q_q[0], q_q[WIDTH-1:1]};
              sout_d = q_q[0];
            end
            M_ASR: begin
              q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
              sout_d = q_q[0];
            end
            default: q_d = q_q;
          endcase
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    q    = q_q;
    sout = sout_q;
    busy = busy_q;
    done = done_q;
  end

endmodule
